// File: rtl/cache_arb_pkg.sv
// cache_arb_pkg: shared state encoding, owner ids and bus widths for the cache memory arbiter
package cache_arb_pkg;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int STRB_W = 4;
    localparam logic OWN_INST = 1'b0;
    localparam logic OWN_DATA = 1'b1;
    typedef enum logic [1:0] {IDLE, ADDR, WAIT, DONE} arb_state_t;
endpackage

// File: rtl/arb_rr2.sv
// arb_rr2: combinational two-request round-robin picker (req[0]=inst, req[1]=data)
module arb_rr2
    import cache_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       grant,
    output logic       grant_valid
);
    always_comb begin
        grant_valid = |req;
        grant       = &req ? ~last_grant : (req[1] ? OWN_DATA : OWN_INST);
    end
endmodule

// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: shares one SRAM-like memory port between the I-cache and D-cache,
// one transaction at a time, with a one-cycle done pulse back to the owner.
module cache_mem_arbiter
    import cache_arb_pkg::*;
(
    input  logic              clk,
    input  logic              resetn,
    input  logic              inst_cache_req,
    input  logic [ADDR_W-1:0] inst_cache_addr,
    output logic [DATA_W-1:0] inst_cache_rdata,
    output logic              inst_cache_dok,
    input  logic              data_cache_req,
    input  logic              data_cache_wr,
    input  logic [STRB_W-1:0] data_cache_wstrb,
    input  logic [ADDR_W-1:0] data_cache_addr,
    input  logic [DATA_W-1:0] data_cache_wdata,
    output logic [DATA_W-1:0] data_cache_rdata,
    output logic              data_cache_dok,
    output logic              mem_req,
    output logic              mem_wr,
    output logic [STRB_W-1:0] mem_wstrb,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_addr_ok,
    input  logic              mem_data_ok
);
    arb_state_t        state, state_nx;
    logic              owner, last_grant, grant, grant_valid, wr_q, grant_wr;
    logic [STRB_W-1:0] wstrb_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q, inst_rdata_q, data_rdata_q;

    arb_rr2 u_rr (
        .req         ({data_cache_req, inst_cache_req}),
        .last_grant  (last_grant),
        .grant       (grant),
        .grant_valid (grant_valid)
    );

    assign grant_wr = (grant == OWN_DATA) && data_cache_wr;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= IDLE;
            owner        <= OWN_INST;
            last_grant   <= OWN_DATA;
            wr_q         <= 1'b0;
            wstrb_q      <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            inst_rdata_q <= '0;
            data_rdata_q <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && grant_valid) begin
                owner   <= grant;
                wr_q    <= grant_wr;
                wstrb_q <= grant_wr ? data_cache_wstrb : '0;
                addr_q  <= (grant == OWN_DATA) ? data_cache_addr : inst_cache_addr;
                wdata_q <= (grant == OWN_DATA) ? data_cache_wdata : '0;
            end
            // Each requester keeps its own response register so its rdata holds across the other's transactions.
            if (state == WAIT && mem_data_ok && owner == OWN_DATA)
                data_rdata_q <= mem_rdata;
            if (state == WAIT && mem_data_ok && owner == OWN_INST)
                inst_rdata_q <= mem_rdata;
            if (state == DONE)
                last_grant <= owner;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = grant_valid ? ADDR : IDLE;
            ADDR:    state_nx = mem_addr_ok ? WAIT : ADDR;
            WAIT:    state_nx = mem_data_ok ? DONE : WAIT;
            default: state_nx = IDLE;
        endcase
        mem_req          = state == ADDR;
        mem_wr           = wr_q;
        mem_wstrb        = wstrb_q;
        mem_addr         = addr_q;
        mem_wdata        = wdata_q;
        inst_cache_dok   = state == DONE && owner == OWN_INST;
        data_cache_dok   = state == DONE && owner == OWN_DATA;
        inst_cache_rdata = inst_rdata_q;
        data_cache_rdata = data_rdata_q;
    end
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb_cache_mem_arbiter: directed plus randomized checks of the cache memory arbiter
// against a transaction-level reference model.
module tb_cache_mem_arbiter;
    logic        clk = 1'b0, resetn = 1'b1;
    logic        inst_cache_req = 0, inst_cache_dok;
    logic [31:0] inst_cache_addr = 0, inst_cache_rdata;
    logic        data_cache_req = 0, data_cache_wr = 0, data_cache_dok;
    logic [3:0]  data_cache_wstrb = 0;
    logic [31:0] data_cache_addr = 0, data_cache_wdata = 0, data_cache_rdata;
    logic        mem_req, mem_wr, mem_addr_ok = 0, mem_data_ok = 0;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr, mem_wdata, mem_rdata = 0;

    int          n_assert = 0, n_fail = 0, lat, pat;
    logic        m_last;
    logic [31:0] m_inst_rd, m_data_rd;

    always #5 clk = ~clk;

    cache_mem_arbiter dut (
        .clk              (clk),
        .resetn           (resetn),
        .inst_cache_req   (inst_cache_req),
        .inst_cache_addr  (inst_cache_addr),
        .inst_cache_rdata (inst_cache_rdata),
        .inst_cache_dok   (inst_cache_dok),
        .data_cache_req   (data_cache_req),
        .data_cache_wr    (data_cache_wr),
        .data_cache_wstrb (data_cache_wstrb),
        .data_cache_addr  (data_cache_addr),
        .data_cache_wdata (data_cache_wdata),
        .data_cache_rdata (data_cache_rdata),
        .data_cache_dok   (data_cache_dok),
        .mem_req          (mem_req),
        .mem_wr           (mem_wr),
        .mem_wstrb        (mem_wstrb),
        .mem_addr         (mem_addr),
        .mem_wdata        (mem_wdata),
        .mem_rdata        (mem_rdata),
        .mem_addr_ok      (mem_addr_ok),
        .mem_data_ok      (mem_data_ok)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_values();
        check("rst_req", 32'(mem_req), 32'd0);
        check("rst_wr", 32'(mem_wr), 32'd0);
        check("rst_strb", 32'(mem_wstrb), 32'd0);
        check("rst_addr", mem_addr, 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        check("rst_dok", 32'({inst_cache_dok, data_cache_dok}), 32'd0);
        check("rst_inst_rdata", inst_cache_rdata, 32'd0);
        check("rst_data_rdata", data_cache_rdata, 32'd0);
    endtask

    // Acts as the memory for one transaction; the model decides who should own it from the held requests.
    task automatic serve(input int a_dly, input int d_dly, input logic [31:0] rd, output int lat_o);
        logic        own, e_wr;
        logic [3:0]  e_strb;
        logic [31:0] e_addr;
        int          n = 0;
        while (mem_req !== 1'b1 && n < 8) begin
            @(negedge clk);
            n++;
        end
        check("grant_req", 32'(mem_req), 32'd1);
        own    = (inst_cache_req && data_cache_req) ? ~m_last : data_cache_req;
        e_wr   = own & data_cache_wr;
        e_strb = e_wr ? data_cache_wstrb : 4'h0;
        e_addr = own ? data_cache_addr : inst_cache_addr;
        for (int i = 0; i <= a_dly; i++) begin
            check("addr_req", 32'(mem_req), 32'd1);
            check("addr_wr", 32'(mem_wr), 32'(e_wr));
            check("addr_strb", 32'(mem_wstrb), 32'(e_strb));
            check("addr_addr", mem_addr, e_addr);
            if (own) check("addr_wdata", mem_wdata, data_cache_wdata);
            check("addr_dok", 32'({inst_cache_dok, data_cache_dok}), 32'd0);
            mem_addr_ok = (i == a_dly);
            mem_data_ok = 1'($urandom);
            mem_rdata   = $urandom;
            @(negedge clk);
            n++;
        end
        mem_addr_ok = 0;
        mem_data_ok = 0;
        check("wait_req", 32'(mem_req), 32'd0);
        for (int i = 0; i < d_dly; i++) begin
            mem_addr_ok = 1'($urandom);
            @(negedge clk);
            n++;
            check("wait_dok", 32'({inst_cache_dok, data_cache_dok}), 32'd0);
            check("wait_req2", 32'(mem_req), 32'd0);
        end
        mem_addr_ok = 0;
        mem_data_ok = 1;
        mem_rdata   = rd;
        @(negedge clk);
        n++;
        check("done_inst_dok", 32'(inst_cache_dok), 32'(!own));
        check("done_data_dok", 32'(data_cache_dok), 32'(own));
        if (own) begin
            m_data_rd = rd;
            data_cache_req = 0;
        end else begin
            m_inst_rd = rd;
            inst_cache_req = 0;
        end
        check("done_inst_rdata", inst_cache_rdata, m_inst_rd);
        check("done_data_rdata", data_cache_rdata, m_data_rd);
        m_last      = own;
        lat_o       = n;
        mem_data_ok = 1'($urandom);
        mem_rdata   = $urandom;
        @(negedge clk);
        mem_data_ok = 0;
        check("post_dok", 32'({inst_cache_dok, data_cache_dok}), 32'd0);
        check("post_inst_rdata", inst_cache_rdata, m_inst_rd);
        check("post_data_rdata", data_cache_rdata, m_data_rd);
    endtask

    task automatic do_reset();
        resetn = 0;
        m_last = 1'b1;
        m_inst_rd = 0;
        m_data_rd = 0;
        repeat (2) @(negedge clk);
        check_reset_values();
        resetn = 1;
        @(negedge clk);
    endtask

    initial begin
        #1;
        do_reset();
        mem_data_ok = 1;
        mem_addr_ok = 1;
        @(negedge clk);
        mem_data_ok = 0;
        mem_addr_ok = 0;
        check("idle_spur_req", 32'(mem_req), 32'd0);
        check("idle_spur_dok", 32'({inst_cache_dok, data_cache_dok}), 32'd0);

        inst_cache_req  = 1;
        inst_cache_addr = 32'h1FC0_0000;
        serve(0, 0, 32'h3C08_BFC0, lat);
        check("inst_latency", 32'(lat), 32'd3);
        check("inst_rdata_val", inst_cache_rdata, 32'h3C08_BFC0);

        data_cache_req   = 1;
        data_cache_wr    = 1;
        data_cache_addr  = 32'h8000_1004;
        data_cache_wdata = 32'hDEAD_BEEF;
        data_cache_wstrb = 4'b0011;
        serve(3, 1, 32'h1234_5678, lat);

        do_reset();
        inst_cache_req   = 1;
        inst_cache_addr  = 32'h0000_0100;
        data_cache_req   = 1;
        data_cache_wr    = 0;
        data_cache_addr  = 32'h0000_0200;
        serve(0, 0, 32'hAAAA_0001, lat);
        check("tie1_inst_first", 32'(m_last), 32'd0);
        inst_cache_req  = 1;
        inst_cache_addr = 32'h0000_0104;
        serve(1, 0, 32'hAAAA_0002, lat);
        check("tie2_data_first", 32'(m_last), 32'd1);
        serve(0, 2, 32'hAAAA_0003, lat);

        inst_cache_req  = 1;
        inst_cache_addr = 32'h0000_0300;
        for (int i = 0; i < 8 && mem_req !== 1'b1; i++) @(negedge clk);
        check("rstw_req", 32'(mem_req), 32'd1);
        mem_addr_ok = 1;
        @(negedge clk);
        mem_addr_ok = 0;
        check("rstw_in_wait", 32'(mem_req), 32'd0);
        #2 resetn = 0;
        #1;
        m_last = 1'b1;
        m_inst_rd = 0;
        m_data_rd = 0;
        check_reset_values();
        @(negedge clk);
        resetn = 1;
        serve(2, 1, 32'h5555_AAAA, lat);

        for (int k = 0; k < 20; k++) begin
            pat = $urandom_range(1, 3);
            inst_cache_req   = pat[0];
            data_cache_req   = pat[1];
            inst_cache_addr  = $urandom;
            data_cache_addr  = $urandom;
            data_cache_wdata = $urandom;
            data_cache_wr    = 1'($urandom);
            data_cache_wstrb = 4'($urandom);
            while (inst_cache_req || data_cache_req)
                serve($urandom_range(0, 3), $urandom_range(0, 3), $urandom, lat);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
